cla32_sub_pipe: RTL
===================

CLA32_SUB_PIPE -- requirements
Module: cla32_sub_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; SHALL be a multiple of 8 and at least 16; low half LW = WIDTH/2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  operand beat offered.
REQ-005 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-006 Port: a  input  WIDTH  minuend, unsigned or two's complement.
REQ-007 Port: b  input  WIDTH  subtrahend.
REQ-008 Port: bin  input  1  borrow-in.
REQ-009 Port: out_valid  output  1  result beat presented.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 Port: bout  output  1  borrow-out; 1 when unsigned a < b + bin.
REQ-013 Port: ovf  output  1  signed overflow of the subtraction.
REQ-014 Port: zero  output  1  diff == 0.

Function
REQ-015 Arithmetic: diff = a + ~b + !bin; carry-in to the LSB SHALL be !bin; bout SHALL be the inverted carry out of the MSB.
REQ-016 Adder structure: each half SHALL be built from 4-bit carry-lookahead groups with the group carry rippled between groups.
REQ-017 Stage 1: on accept (in_valid && in_ready), the block SHALL register diff[LW-1:0], the borrow out of bit LW-1, a[WIDTH-1:LW], b[WIDTH-1:LW] and a[WIDTH-1]; s1_valid SHALL be set.
REQ-018 Stage 2: on stage-1 advance, the block SHALL compute the upper half from the registered borrow and register the full diff, bout, ovf and zero; s2_valid SHALL be set.
REQ-019 ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-020 Latency: a beat accepted in cycle N SHALL present out_valid in cycle N+2 when there is no backpressure; throughput SHALL be 1 beat per cycle.
REQ-021 Stage-2 hold: when out_valid && !out_ready, diff, bout, ovf and zero SHALL stay stable and out_valid SHALL stay 1.
REQ-022 Stage 1 SHALL advance when s1_valid && (!s2_valid || out_ready).
REQ-023 in_ready = !s1_valid || stage-1 advance; combinational, with no dependency on in_valid.
REQ-024 Simultaneous events: output handshake, stage-1 advance and input accept in the same cycle SHALL all take effect without a lost or duplicated beat.
REQ-025 Stage 2 SHALL clear s2_valid when out_ready is 1 and stage 1 is not advancing.
REQ-026 Beats SHALL leave in acceptance order; the block SHALL NOT drop, reorder or duplicate beats.
REQ-027 Operand inputs SHALL be sampled only on the accepting edge; changes at any other time SHALL have no effect.

Reset
REQ-028 While rst_n is 0: s1_valid = 0, s2_valid = 0, out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0.
REQ-029 While rst_n is 0, in_ready SHALL be 1 (it follows from empty stage 1).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats immediately, with no output handshake completing afterwards.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Basic: a=0x0000_0005, b=0x0000_0003, bin=0 -> diff=0x0000_0002, bout=0, ovf=0, zero=0, out_valid exactly 2 cycles after accept.
REQ-033 Cross-half borrow: a=0x0001_0000, b=0x0000_0001, bin=0 -> diff=0x0000_FFFF, bout=0.
REQ-034 Wrap and borrow-in: a=0, b=0, bin=1 -> diff=0xFFFF_FFFF, bout=1, zero=0; then a=b=0x1234_5678, bin=0 -> diff=0, zero=1, bout=0.
REQ-035 Signed overflow: a=0x8000_0000, b=0x0000_0001 -> diff=0x7FFF_FFFF, ovf=1, bout=0; then a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, ovf=1, bout=1.
REQ-036 Backpressure: stream 4 beats with out_ready=0 -> in_ready falls after 2 accepts and the stage-2 output holds stable; then raise out_ready -> all 4 results appear in order, 1 per cycle, with no gaps while in_valid stays 1.
REQ-037 Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 and in_ready=1 at once; after release, one beat a=9, b=4 -> diff=5 after 2 cycles.

Source files
------------

// File: rtl/cla32_sub_pipe.sv
// Two-stage pipelined subtractor: the low half is resolved in stage 1 and the high half in stage 2.
// Each half is a chain of 4-bit carry-lookahead groups, with a valid/ready handshake on both sides.

module cla_chain #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;
  logic         carry;

  assign g = x & y;
  assign p = x ^ y;

  // Carries are looked ahead inside each group; the group carry then ripples to the next group.
  always_comb begin
    c     = '0;
    carry = cin;
    for (int k = 0; k < N / 4; k++) begin
      c[4*k]   = carry;
      c[4*k+1] = g[4*k] | (p[4*k] & carry);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
      carry    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & carry);
    end
    sum  = p ^ c;
    cout = carry;
  end
endmodule

module cla32_sub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int LW = WIDTH / 2;

  logic             s1_valid_q, s1_valid_d;
  logic [LW-1:0]    s1_lo_q, s1_lo_d;
  logic             s1_borrow_q, s1_borrow_d;
  logic [LW-1:0]    s1_ah_q, s1_ah_d;
  logic [LW-1:0]    s1_bh_q, s1_bh_d;
  logic             s1_amsb_q, s1_amsb_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [LW-1:0]    lo_sum;
  logic             lo_cout;
  logic [LW-1:0]    hi_sum;
  logic             hi_cout;
  logic             s1_adv;
  logic             accept;

  // Subtraction as a + ~b + !bin; a carry out of a half means "no borrow".
  cla_chain #(.N(LW)) u_lo (
    .x    (a[LW-1:0]),
    .y    (~b[LW-1:0]),
    .cin  (~bin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_chain #(.N(LW)) u_hi (
    .x    (s1_ah_q),
    .y    (~s1_bh_q),
    .cin  (~s1_borrow_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_borrow_d = s1_borrow_q;
    s1_ah_d     = s1_ah_q;
    s1_bh_d     = s1_bh_q;
    s1_amsb_d   = s1_amsb_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_lo_d     = lo_sum;
      s1_borrow_d = ~lo_cout;
      s1_ah_d     = a[WIDTH-1:LW];
      s1_bh_d     = b[WIDTH-1:LW];
      s1_amsb_d   = a[WIDTH-1];
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end
  end

  // Stage 2 holds its result until the consumer takes it, unless a new beat moves in.
  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      diff_d     = {hi_sum, s1_lo_q};
      bout_d     = ~hi_cout;
      ovf_d      = (s1_amsb_q != s1_bh_q[LW-1]) && (hi_sum[LW-1] != s1_amsb_q);
      zero_d     = ({hi_sum, s1_lo_q} == '0);
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_borrow_q <= 1'b0;
      s1_ah_q     <= '0;
      s1_bh_q     <= '0;
      s1_amsb_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_borrow_q <= s1_borrow_d;
      s1_ah_q     <= s1_ah_d;
      s1_bh_q     <= s1_bh_d;
      s1_amsb_q   <= s1_amsb_d;
      s2_valid_q  <= s2_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule
